ps2_rx_ctrl: RTL and testbench
==============================

# ps2_rx_ctrl

Synchronous PS/2 receive controller for the keyboard peripheral. It samples the raw `ps2_clk`/`ps2_data` lines in the system clock domain and sequences each 11-bit frame through a state machine. It checks start, parity and stop bits, aborts stalled frames on a watchdog, and buffers good bytes in a small FIFO drained through a valid/ready port. It sits between the PS/2 pins and the APB register front-end. All logic runs on `clock`; there is no logic clocked by `ps2_clk`.

## Interface
- `FIFO_DEPTH`, 16: receive FIFO entries; power of two, at least 2.
- `TIMEOUT_CYCLES`, 50000: `clock` cycles allowed between falling edges inside a frame.
- `clock` input 1: system clock; all state is updated on its rising edge.
- `reset` input 1: reset is asynchronous and active-high.
- `ps2_clk` input 1: raw PS/2 clock line, asynchronous to `clock`.
- `ps2_data` input 1: raw PS/2 data line, asynchronous to `clock`.
- `rx_valid` output 1: FIFO not empty.
- `rx_data` output 8: byte at the FIFO head; valid only while `rx_valid` is high.
- `rx_ready` input 1: consumer pop; a pop happens when `rx_valid && rx_ready`.
- `fifo_level` output $clog2(FIFO_DEPTH)+1: number of entries held.
- `busy` output 1: FSM is not in IDLE.
- `frame_err` output 1: one-cycle pulse on a bad stop bit.
- `parity_err` output 1: one-cycle pulse on a bad parity bit.
- `timeout_err` output 1: one-cycle pulse on a watchdog abort.
- `overflow` output 1: sticky flag; a byte was dropped because the FIFO was full.
- `clear_ovf` input 1: synchronous clear of `overflow`.

## Operation
- Each line passes through a 2-flop synchronizer, followed by one history flop. `fall` is asserted when the history flop is 1 and the synchronized clock is 0. All frame sampling uses synchronized `ps2_data` in the `fall` cycle.
- FSM states are IDLE, DATA, PARITY and STOP.
  - IDLE: on `fall` with data=0 (start bit), go to DATA and clear `bit_cnt` and the shift register. On `fall` with data=1, stay in IDLE and ignore it as a glitch.
  - DATA: on each `fall`, shift data in LSB first (`shreg <= {d, shreg[7:1]}`) and increment `bit_cnt`. When `bit_cnt`==7 is sampled, go to PARITY.
  - PARITY: on `fall`, latch the parity bit and go to STOP.
  - STOP: on `fall`, evaluate the frame and return to IDLE.
    - Stop=0: pulse `frame_err` and discard the byte.
    - Else, bad parity (see Configuration): pulse `parity_err` and discard the byte.
    - Else, push the byte.
  - If stop=0 and parity is also bad, only `frame_err` is pulsed.
- Watchdog: a counter clears on every `fall` and while in IDLE, and increments otherwise. When it reaches `TIMEOUT_CYCLES`-1 outside IDLE, the FSM returns to IDLE, the partial byte is discarded and `timeout_err` pulses. The next `fall` is then treated as a possible start bit.
- FIFO: read and write pointers carry one extra wrap bit.
  - Empty when the pointers are equal. Full when the low bits are equal and the wrap bits differ.
  - A push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and `overflow` is set. `overflow` stays set until `clear_ovf`; if set and clear coincide, set wins.
  - `rx_data` is a combinational read of the head entry.
- Reset values: FSM=IDLE, pointers=0, synchronizer and history flops=1 (idle bus), `overflow`=0, all pulses=0. Resulting outputs: `rx_valid`=0, `fifo_level`=0, `busy`=0, `rx_data`=0. Reset mid-frame discards the partial byte and all FIFO contents.

## Timing
- A `ps2_clk` falling edge reaches `fall` 2–3 `clock` cycles later; this is the synchronizer latency.
- The push is registered in the STOP `fall` cycle, so `rx_valid` rises and `fifo_level` increments one cycle later.
- A pop in cycle N presents the next head at `rx_data` in cycle N+1. `rx_valid` falls in N+1 if the FIFO becomes empty.
- Error pulses are registered and high for exactly one cycle, one cycle after the triggering `fall` or timeout.
- `clock` must be at least 8× the PS/2 bit rate, i.e. ≥ 200 kHz for a 25 kHz line.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: odd parity is required (ones in data plus parity is odd). A mismatch drops the byte and pulses `parity_err`.
- `PS2_PARITY_CHECK_EN` undefined: the parity bit is sampled but ignored, and `parity_err` is tied to 0.

## Structure
- Package `ps2_pkg` holds the FSM state enum, `PS2_DATA_BITS`=8, and the default `FIFO_DEPTH`/`TIMEOUT_CYCLES` constants.
- Sub-module `ps2_rx_fifo` contains the storage, the pointers, the level counter and the full/empty/push/pop rules. The top level holds the synchronizer, edge detect, FSM, watchdog and error flags.

## Test plan
- Frame 0x1C with parity 0 and stop 1 → `rx_valid`=1, `rx_data`=0x1C, `fifo_level`=1; `rx_ready` pulse → `rx_valid`=0.
- Frames 0xF0 (parity 1) then 0x1C → two bytes popped in order 0xF0, 0x1C; no error pulses.
- Frame 0x1C with parity 1 → with the macro: `parity_err` pulse and no push. Without the macro: 0x1C pushed.
- Frame 0x5A with stop bit 0 → one `frame_err` pulse, `fifo_level` stays 0, next valid frame is received normally.
- Start bit plus 3 data bits, then the line is held idle for `TIMEOUT_CYCLES` → `timeout_err` pulse, `busy`=0, following frame 0x1C is received.
- FIFO_DEPTH+1 frames with no pops → `fifo_level`=FIFO_DEPTH, `overflow`=1, first byte intact. `clear_ovf` → `overflow`=0. Reset asserted mid-frame → `rx_valid`=0, `busy`=0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and FSM state encoding for the PS/2 receive path.
package ps2_pkg;

   localparam int PS2_DATA_BITS      = 8;
   localparam int PS2_FIFO_DEPTH     = 16;
   localparam int PS2_TIMEOUT_CYCLES = 50000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_e;

endpackage

// File: rtl/ps2_rx_fifo.sv
// Receive byte FIFO with wrap-bit pointers; a push into a full FIFO is
// still accepted when a pop happens in the same cycle.
module ps2_rx_fifo #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     pop_req,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     drop
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic              empty;
   logic              full;
   logic              pop;
   logic              accept;

   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign pop    = pop_req && !empty;
   assign accept = push && (!full || pop);
   assign drop   = push && !accept;

   always_ff @(posedge clock) begin
      if (accept)
         mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (accept)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage is never reset, so the head is masked to zero while empty.
   assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
   assign valid   = !empty;
   assign level   = wr_ptr - rd_ptr;

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 receive controller: synchronizer, falling-edge detect, frame FSM,
// watchdog and error flags. Define PS2_PARITY_CHECK_EN to enforce odd parity.
module ps2_rx_ctrl
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = PS2_FIFO_DEPTH,
   parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   output logic                          rx_valid,
   output logic [PS2_DATA_BITS-1:0]      rx_data,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          busy,
   output logic                          frame_err,
   output logic                          parity_err,
   output logic                          timeout_err,
   output logic                          overflow,
   input  logic                          clear_ovf
);

   localparam logic [1:0] S_IDLE   = ST_IDLE;
   localparam logic [1:0] S_DATA   = ST_DATA;
   localparam logic [1:0] S_PARITY = ST_PARITY;
   localparam logic [1:0] S_STOP   = ST_STOP;
   localparam int         WD_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic                     clk_p0, clk_p1, clk_p2;
   logic                     data_p0, data_p1;
   logic                     fall;
   logic                     d;
   logic [1:0]               state;
   logic [2:0]               bit_cnt;
   logic [PS2_DATA_BITS-1:0] shreg;
   logic                     parity_bit;
   logic [WD_W-1:0]          wd_cnt;
   logic                     timeout;
   logic                     stop_fall;
   logic                     parity_ok;
   logic                     push;
   logic                     drop;

   // Synchronizer stage, then one history flop for edge detection
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         clk_p0  <= 1'b1;
         clk_p1  <= 1'b1;
         clk_p2  <= 1'b1;
         data_p0 <= 1'b1;
         data_p1 <= 1'b1;
      end else begin
         clk_p0  <= ps2_clk;
         clk_p1  <= clk_p0;
         clk_p2  <= clk_p1;
         data_p0 <= ps2_data;
         data_p1 <= data_p0;
      end
   end

   assign fall      = clk_p2 && !clk_p1;
   assign d         = data_p1;
   assign timeout   = (state != S_IDLE) && !fall && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
   assign stop_fall = (state == S_STOP) && fall;

`ifdef PS2_PARITY_CHECK_EN
   assign parity_ok = ^{shreg, parity_bit};
`else
   logic parity_unused;
   assign parity_unused = parity_bit;
   assign parity_ok     = 1'b1;
`endif

   assign push = stop_fall && d && parity_ok;

   // Frame sequencing stage
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         bit_cnt <= '0;
         wd_cnt  <= '0;
      end else begin
         wd_cnt <= (state == S_IDLE || fall) ? '0 : wd_cnt + 1'b1;
         if (timeout) begin
            state <= S_IDLE;
         end else if (fall) begin
            case (state)
               S_IDLE: begin
                  if (!d) begin
                     state   <= S_DATA;
                     bit_cnt <= '0;
                  end
               end
               S_DATA: begin
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7)
                     state <= S_PARITY;
               end
               S_PARITY: state <= S_STOP;
               default:  state <= S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clock) begin
      if (fall) begin
         if (state == S_IDLE && !d)
            shreg <= '0;
         else if (state == S_DATA)
            shreg <= {d, shreg[PS2_DATA_BITS-1:1]};
         if (state == S_PARITY)
            parity_bit <= d;
      end
   end

   // Registered status flags
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         frame_err   <= 1'b0;
         parity_err  <= 1'b0;
         timeout_err <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         frame_err   <= stop_fall && !d;
         parity_err  <= stop_fall && d && !parity_ok;
         timeout_err <= timeout;
         if (drop)
            overflow <= 1'b1;
         else if (clear_ovf)
            overflow <= 1'b0;
      end
   end

   assign busy = (state != S_IDLE);

   ps2_rx_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (PS2_DATA_BITS)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (push),
      .wr_data (shreg),
      .pop_req (rx_ready),
      .rd_data (rx_data),
      .valid   (rx_valid),
      .level   (fifo_level),
      .drop    (drop)
   );

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Directed scoreboard bench for ps2_rx_ctrl with a small FIFO and short watchdog.
module tb_ps2_rx_ctrl;

   localparam int DEPTH = 4;
   localparam int TMO   = 300;

   logic                   clock = 1'b0;
   logic                   reset = 1'b1;
   logic                   ps2_clk = 1'b1;
   logic                   ps2_data = 1'b1;
   logic                   rx_valid;
   logic [7:0]             rx_data;
   logic                   rx_ready = 1'b0;
   logic [$clog2(DEPTH):0] fifo_level;
   logic                   busy;
   logic                   frame_err;
   logic                   parity_err;
   logic                   timeout_err;
   logic                   overflow;
   logic                   clear_ovf = 1'b0;

   int checks = 0;
   int errors = 0;
   int fe_cnt = 0;
   int pe_cnt = 0;
   int te_cnt = 0;
   logic [7:0] exp_q[$];

   ps2_rx_ctrl #(
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .rx_ready    (rx_ready),
      .fifo_level  (fifo_level),
      .busy        (busy),
      .frame_err   (frame_err),
      .parity_err  (parity_err),
      .timeout_err (timeout_err),
      .overflow    (overflow),
      .clear_ovf   (clear_ovf)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (!reset) begin
         if (frame_err)   fe_cnt <= fe_cnt + 1;
         if (parity_err)  pe_cnt <= pe_cnt + 1;
         if (timeout_err) te_cnt <= te_cnt + 1;
      end
   end

   initial begin
      #500us;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1, "simulation time limit");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      wait_clk(5);
      ps2_clk = 1'b0;
      wait_clk(10);
      ps2_clk = 1'b1;
      wait_clk(5);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(par);
      send_bit(stp);
      ps2_data = 1'b1;
      wait_clk(4);
   endtask

   task automatic send_good(input logic [7:0] b);
      send_frame(b, ~^b, 1'b1);
      exp_q.push_back(b);
   endtask

   task automatic pop_check(input string tag);
      logic [7:0] e;
      check({tag, "_qsize"}, (exp_q.size() > 0), 1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      check({tag, "_valid"}, rx_valid, 1);
      check({tag, "_data"}, rx_data, e);
      rx_ready = 1'b1;
      wait_clk(1);
      rx_ready = 1'b0;
      wait_clk(1);
   endtask

   initial begin
      wait_clk(3);
      check("rst_valid", rx_valid, 0);
      check("rst_level", fifo_level, 0);
      check("rst_busy", busy, 0);
      check("rst_data", rx_data, 0);
      check("rst_ovf", overflow, 0);
      reset = 1'b0;
      wait_clk(3);

      // Single byte
      send_good(8'h1C);
      check("one_level", fifo_level, 1);
      pop_check("one_pop");
      check("one_empty", rx_valid, 0);

      // Two bytes in order
      send_good(8'hF0);
      send_good(8'h1C);
      check("two_level", fifo_level, 2);
      pop_check("two_pop0");
      pop_check("two_pop1");
      check("two_empty", rx_valid, 0);
      check("two_noerr", fe_cnt + pe_cnt + te_cnt, 0);

      // Wrong parity
      send_frame(8'h1C, 1'b1, 1'b1);
      wait_clk(2);
`ifdef PS2_PARITY_CHECK_EN
      check("par_pulse", pe_cnt, 1);
      check("par_level", fifo_level, 0);
`else
      exp_q.push_back(8'h1C);
      check("par_nopulse", pe_cnt, 0);
      check("par_level", fifo_level, 1);
      pop_check("par_pop");
`endif

      // Bad stop bit
      send_frame(8'h5A, ~^8'h5A, 1'b0);
      wait_clk(2);
      check("frm_pulse", fe_cnt, 1);
      check("frm_level", fifo_level, 0);
      send_good(8'h33);
      pop_check("frm_next");

      // Watchdog abort after start + 3 data bits
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      ps2_data = 1'b1;
      check("tmo_busy_mid", busy, 1);
      wait_clk(TMO + 20);
      check("tmo_pulse", te_cnt, 1);
      check("tmo_busy", busy, 0);
      check("tmo_level", fifo_level, 0);
      send_good(8'h1C);
      pop_check("tmo_next");
      check("err_totals", fe_cnt, 1);

      // Overflow
      for (int i = 0; i < DEPTH; i++) send_good(8'h40 + 8'(i));
      check("ovf_pre", overflow, 0);
      send_frame(8'hA5, ~^8'hA5, 1'b1);
      check("ovf_level", fifo_level, DEPTH);
      check("ovf_set", overflow, 1);
      check("ovf_head", rx_data, exp_q[0]);
      clear_ovf = 1'b1;
      wait_clk(1);
      clear_ovf = 1'b0;
      wait_clk(1);
      check("ovf_clear", overflow, 0);
      for (int i = 0; i < DEPTH; i++) pop_check("ovf_drain");
      check("ovf_empty", rx_valid, 0);

      // Reset in the middle of a frame with a byte already buffered
      send_frame(8'h77, ~^8'h77, 1'b1);
      check("mid_valid_pre", rx_valid, 1);
      send_bit(1'b0);
      send_bit(1'b1);
      check("mid_busy_pre", busy, 1);
      reset = 1'b1;
      wait_clk(2);
      reset = 1'b0;
      wait_clk(2);
      check("mid_valid", rx_valid, 0);
      check("mid_busy", busy, 0);
      check("mid_level", fifo_level, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
